// File: rtl/ps2_coord_entry.sv
// rtl/ps2_coord_entry.sv - PS/2 Set-2 receiver and letter/number/Enter coordinate assembler
module ps2_coord_entry #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 27000
) (
  input  logic       clock27,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [3:0] letter,
  output logic [3:0] number,
  output logic       cmd_valid,
  output logic [1:0] entry_state,
  output logic [8:0] keyDataOut,
  output logic       key_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    WAIT_LETTER = 2'd0,
    WAIT_NUMBER = 2'd1,
    WAIT_ENTER  = 2'd2
  } state_t;

  logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic          r_clk_filt, r_clk_filt_d;
  logic [FW-1:0] r_filt_cnt;
  logic          w_fall;

  logic [3:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_par;
  logic [TW-1:0] r_to_cnt;
  logic          r_byte_rdy;
  logic [7:0]    r_byte;
  logic          r_frame_err;

  logic          r_ext, r_brk;
  logic [8:0]    r_key;
  logic          r_key_valid;
  state_t        r_state;
  logic [3:0]    r_letter, r_number;
  logic          r_cmd_valid;

  logic          w_let_hit, w_dig_hit, w_is_letter, w_is_digit, w_is_enter, w_is_bksp;
  logic [3:0]    w_let_val, w_dig_val;

  // Two-flop synchronizers for the asynchronous PS/2 lines; idle level is high
  always_ff @(posedge clock27) begin
    if (reset) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_dat;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // Glitch filter: the filtered clock follows only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clock27) begin
    if (reset) begin
      r_clk_filt   <= 1'b1;
      r_clk_filt_d <= 1'b1;
      r_filt_cnt   <= '0;
    end else begin
      r_clk_filt_d <= r_clk_filt;
      if (r_clk_s2 == r_clk_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
        r_clk_filt <= r_clk_s2;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  // High on the first cycle the filtered clock is low; data is sampled here
  assign w_fall = r_clk_filt_d & ~r_clk_filt;

  // Frame receiver: start, 8 data LSB first, odd parity, stop; abandons stalled frames
  always_ff @(posedge clock27) begin
    if (reset) begin
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_par       <= 1'b0;
      r_to_cnt    <= '0;
      r_byte_rdy  <= 1'b0;
      r_byte      <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_byte_rdy  <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_fall) begin
        r_to_cnt <= '0;
        if (r_bit_cnt == 4'd0) begin
          if (!r_dat_s2) r_bit_cnt <= 4'd1;
        end else if (r_bit_cnt <= 4'd8) begin
          r_shift   <= {r_dat_s2, r_shift[7:1]};
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end else if (r_bit_cnt == 4'd9) begin
          r_par     <= r_dat_s2;
          r_bit_cnt <= 4'd10;
        end else begin
          r_bit_cnt <= '0;
          if (r_dat_s2 && (^{r_shift, r_par})) begin
            r_byte     <= r_shift;
            r_byte_rdy <= 1'b1;
          end else begin
            r_frame_err <= 1'b1;
          end
        end
      end else if (r_bit_cnt != 4'd0) begin
        if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          r_bit_cnt <= '0;
          r_to_cnt  <= '0;
        end else begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  // Set-2 scan code decode of the received byte into key classes
  always_comb begin
    w_let_hit = 1'b1;
    w_let_val = 4'd0;
    case (r_byte)
      8'h1C: w_let_val = 4'd0;
      8'h32: w_let_val = 4'd1;
      8'h21: w_let_val = 4'd2;
      8'h23: w_let_val = 4'd3;
      8'h24: w_let_val = 4'd4;
      8'h2B: w_let_val = 4'd5;
      8'h34: w_let_val = 4'd6;
      8'h33: w_let_val = 4'd7;
      8'h43: w_let_val = 4'd8;
      8'h3B: w_let_val = 4'd9;
      default: w_let_hit = 1'b0;
    endcase
    w_dig_hit = 1'b1;
    w_dig_val = 4'd0;
    case (r_byte)
      8'h45: w_dig_val = 4'd0;
      8'h16: w_dig_val = 4'd1;
      8'h1E: w_dig_val = 4'd2;
      8'h26: w_dig_val = 4'd3;
      8'h25: w_dig_val = 4'd4;
      8'h2E: w_dig_val = 4'd5;
      8'h36: w_dig_val = 4'd6;
      8'h3D: w_dig_val = 4'd7;
      8'h3E: w_dig_val = 4'd8;
      8'h46: w_dig_val = 4'd9;
      default: w_dig_hit = 1'b0;
    endcase
    w_is_letter = w_let_hit & ~r_ext;
    w_is_digit  = w_dig_hit & ~r_ext;
    w_is_enter  = (r_byte == 8'h5A);
    w_is_bksp   = (r_byte == 8'h66);
  end

  // Prefix tracking, key output and the letter -> number -> Enter entry FSM
  always_ff @(posedge clock27) begin
    if (reset) begin
      r_ext       <= 1'b0;
      r_brk       <= 1'b0;
      r_key       <= '0;
      r_key_valid <= 1'b0;
      r_state     <= WAIT_LETTER;
      r_letter    <= '0;
      r_number    <= '0;
      r_cmd_valid <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      r_cmd_valid <= 1'b0;
      if (r_byte_rdy) begin
        if (r_byte == 8'hE0) begin
          r_ext <= 1'b1;
        end else if (r_byte == 8'hF0) begin
          r_brk <= 1'b1;
        end else begin
          r_key       <= {r_ext, r_byte};
          r_key_valid <= 1'b1;
          r_ext       <= 1'b0;
          r_brk       <= 1'b0;
          if (!r_brk) begin
            case (r_state)
              WAIT_LETTER: begin
                if (w_is_letter) begin
                  r_letter <= w_let_val;
                  r_state  <= WAIT_NUMBER;
                end
              end
              WAIT_NUMBER: begin
                if (w_is_digit) begin
                  r_number <= w_dig_val;
                  r_state  <= WAIT_ENTER;
                end else if (w_is_letter) begin
                  r_letter <= w_let_val;
                end else if (w_is_bksp) begin
                  r_state <= WAIT_LETTER;
                end
              end
              WAIT_ENTER: begin
                if (w_is_enter) begin
                  r_cmd_valid <= 1'b1;
                  r_state     <= WAIT_LETTER;
                end else if (w_is_digit) begin
                  r_number <= w_dig_val;
                end else if (w_is_letter) begin
                  r_letter <= w_let_val;
                  r_state  <= WAIT_NUMBER;
                end else if (w_is_bksp) begin
                  r_state <= WAIT_NUMBER;
                end
              end
              default: r_state <= WAIT_LETTER;
            endcase
          end
        end
      end
    end
  end

  assign letter      = r_letter;
  assign number      = r_number;
  assign cmd_valid   = r_cmd_valid;
  assign entry_state = r_state;
  assign keyDataOut  = r_key;
  assign key_valid   = r_key_valid;
  assign frame_err   = r_frame_err;

endmodule

// File: doc/ps2_coord_entry.md
Name: ps2_coord_entry

Overview:
Upstream input stage for the decider. Receives raw PS/2 keyboard frames, decodes Set-2 scan codes for A–J, 0–9, Enter and Backspace, and assembles a letter→number→Enter sequence into one validated board coordinate. Presents `letter`/`number` with a one-cycle `cmd_valid` strobe to the decider, which no longer tracks key order itself.

Parameters:
- FILTER_LEN, default 8: consecutive equal synchronized samples needed to accept a `ps2_clk` level change.
- TIMEOUT_CYCLES, default 27000: cycles without a filtered falling edge before a partial frame is abandoned (1 ms at 27 MHz).

Ports:
- `clock27`, input, 1: system clock, 27 MHz.
- `reset`, input, 1: synchronous, active-high.
- `ps2_clk`, input, 1: raw PS/2 clock, asynchronous.
- `ps2_dat`, input, 1: raw PS/2 data, asynchronous.
- `letter`, output, 4: latched row, A=0 … J=9.
- `number`, output, 4: latched column; keys 1–9 give 1–9, key 0 gives 0 (means 10).
- `cmd_valid`, output, 1: one-cycle pulse, complete coordinate confirmed.
- `entry_state`, output, 2: 0 WAIT_LETTER, 1 WAIT_NUMBER, 2 WAIT_ENTER.
- `keyDataOut`, output, 9: {extended flag, last received non-prefix byte}.
- `key_valid`, output, 1: one-cycle pulse when `keyDataOut` updates (make and break).
- `frame_err`, output, 1: one-cycle pulse on a parity or stop-bit error.

Behaviour:
- **Reset.** Every output is 0, FSM is WAIT_LETTER, E0/F0 flags are clear, and the bit counter is 0. Reset mid-frame discards the partial byte. Resync afterwards is by error discard or timeout.
- **Input conditioning.**
  - `ps2_clk` and `ps2_dat` each pass through a 2-FF synchronizer.
  - Filtered clock changes level only after FILTER_LEN equal samples.
  - Data is sampled on the cycle the filtered clock falls.
- **Frame format.** 11 bits: start(0), D0..D7 LSB first, odd parity, stop(1).
  - Start bit sampled as 1: ignored, counter stays 0.
  - Bad parity or stop bit = 0: byte discarded, `frame_err` pulses on the cycle after the stop sample, counter returns to 0.
  - Good frame: internal `byte_rdy` pulses on the cycle after the stop sample.
- **Timeout.** Counter is nonzero and TIMEOUT_CYCLES elapse with no filtered falling edge: counter returns to 0, no `frame_err`.
- **Prefix handling.**
  - Byte E0 sets `ext`; byte F0 sets `brk`. Neither updates `keyDataOut`.
  - The next non-prefix byte is emitted on `keyDataOut` = {`ext`, byte} with `key_valid`, then both flags clear.
  - Entry FSM acts only on make codes (`brk` = 0).
- **Key decode.**
  - Non-extended letters: A 1C, B 32, C 21, D 23, E 24, F 2B, G 34, H 33, I 43, J 3B.
  - Non-extended digits: 0 45, 1 16, 2 1E, 3 26, 4 25, 5 2E, 6 36, 7 3D, 8 3E, 9 46.
  - Enter: 5A, extended or not. Backspace: 66. Every other code is ignored.
- **Entry FSM** (acts on the `byte_rdy` cycle):
  - WAIT_LETTER: letter → latch `letter`, go WAIT_NUMBER. Digit, Enter, Backspace ignored.
  - WAIT_NUMBER: digit → latch `number`, go WAIT_ENTER. Letter → overwrite `letter`, stay. Backspace → WAIT_LETTER. Enter ignored.
  - WAIT_ENTER: Enter → `cmd_valid` pulses next cycle, go WAIT_LETTER. Digit → overwrite `number`, stay. Letter → overwrite `letter`, go WAIT_NUMBER. Backspace → WAIT_NUMBER.
- **Output stability.** `letter`/`number` hold until the next latch and are stable while `cmd_valid` = 1.
- **Latency.** `cmd_valid` rises exactly 2 `clock27` cycles after the filtered falling edge that samples the Enter frame's stop bit.
- **Reset priority.** Reset on the same cycle as `byte_rdy` wins: no latch, no pulse.

Test Plan:
1. Frames 32, 2E, 5A (B, 5, Enter): `cmd_valid` high exactly 1 cycle with `letter`=1, `number`=5; `entry_state` returns to 0; latency is 2 cycles after the last stop-bit edge.
2. Sequence 3B, F0 3B, 45, F0 45, E0 5A: break codes ignored; `cmd_valid` with `letter`=9, `number`=0; `keyDataOut` sequence is 03B, 03B, 045, 045, 15A.
3. Frame 1C sent with wrong parity: `frame_err` pulses once, `key_valid` stays 0, `entry_state` stays 0.
4. Sequence 1C, 16, 66, 26, 5A: Backspace returns to WAIT_NUMBER; final `cmd_valid` has `letter`=0, `number`=3.
5. Send 5 bits then stop toggling for TIMEOUT_CYCLES+1, then a full 32 frame: no `frame_err`; `letter`=1, `entry_state`=1.
6. Assert `reset` after bit 4 of a frame in WAIT_ENTER: all outputs 0, `entry_state`=0; after the garbled tail, the next clean A, 1, Enter gives `cmd_valid` with `letter`=0, `number`=1.
